// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle between a UART transmitter and its client.
// The tick shares this bundle because it comes from the common 16x baud generator.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_tick;
    logic                 i_tx_start;
    logic [DATA_BITS-1:0] i_tx_data;
    logic                 o_tx_serial;
    logic                 o_tx_busy;
    logic                 o_tx_done;

    modport master (
        output i_tick,
        output i_tx_start,
        output i_tx_data,
        input  o_tx_serial,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_tick,
        input  i_tx_start,
        input  i_tx_data,
        output o_tx_serial,
        output o_tx_busy,
        output o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, then a STOP_TICKS-long stop,
// timed by a shared 16x oversampling tick. All outputs are registered.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic     i_clock,
    input  logic     i_reset_n,
    uart_tx_if.slave bus
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        STOP  = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    localparam logic [4:0] BIT_LAST_TICK  = 5'd15;
    localparam logic [4:0] STOP_LAST_TICK = 5'(STOP_TICKS - 1);
    localparam logic [2:0] LAST_BIT       = 3'(DATA_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic [4:0]           tick_cnt;
    logic [4:0]           tick_cnt_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 serial_q;
    logic                 busy_q;
    logic                 done_q;

    // Line level for a state; anything but START/DATA (including illegal codes) idles high.
    function automatic logic line_level(input state_t s, input logic lsb);
        case (s)
            START:   return 1'b0;
            DATA:    return lsb;
            default: return 1'b1;
        endcase
    endfunction

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            tick_cnt <= 5'd0;
            bit_idx  <= 3'd0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_idx  <= bit_idx_next;
            serial_q <= line_level(state_next, shift_next[0]);
            busy_q   <= (state_next != IDLE);
            done_q   <= (state_next == DONE);
        end
    end

    // Data path carries no reset: its contents are only observed after a fresh load.
    always_ff @(posedge i_clock) begin
        shift_reg <= shift_next;
    end

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        case (state)
            IDLE: begin
                tick_cnt_next = 5'd0;
                bit_idx_next  = 3'd0;
                if (bus.i_tx_start) begin
                    shift_next = bus.i_tx_data;
                    state_next = START;
                end
            end
            START: begin
                if (bus.i_tick) begin
                    if (tick_cnt == BIT_LAST_TICK) begin
                        tick_cnt_next = 5'd0;
                        state_next    = DATA;
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (bus.i_tick) begin
                    if (tick_cnt == BIT_LAST_TICK) begin
                        tick_cnt_next = 5'd0;
                        shift_next    = shift_reg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx_next = 3'd0;
                            state_next   = STOP;
                        end else begin
                            bit_idx_next = bit_idx + 3'd1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (bus.i_tick) begin
                    if (tick_cnt == STOP_LAST_TICK) begin
                        tick_cnt_next = 5'd0;
                        state_next    = DONE;
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            DONE: begin
                tick_cnt_next = 5'd0;
                state_next    = IDLE;
            end
            default: begin
                tick_cnt_next = 5'd0;
                bit_idx_next  = 3'd0;
                state_next    = IDLE;
            end
        endcase
    end

    assign bus.o_tx_serial = serial_q;
    assign bus.o_tx_busy   = busy_q;
    assign bus.o_tx_done   = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART link, counterpart of the existing receiver. It takes a parallel byte with a one-cycle start strobe and shifts it out LSB-first on a single line: start bit, data bits, then stop. Bit timing comes from the shared 16x oversampling tick generator, so transmitter and receiver run off the same baud tick. Completion is signalled by a one-cycle done pulse.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame (5..8).
- STOP_TICKS, 16: stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clock  in  1  system clock; all state changes on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_tick  in  1  one-cycle pulse at 16x baud rate.
- i_tx_start  in  1  request to send; sampled only in IDLE.
- i_tx_data  in  DATA_BITS  byte to send; captured in the cycle the request is accepted.
- o_tx_serial  out  1  serial line, registered, idle high.
- o_tx_busy  out  1  high from the cycle after acceptance through DONE.
- o_tx_done  out  1  one-cycle pulse when the stop bit has completed.

## Operation
- One-hot FSM with states IDLE, START, DATA, STOP, DONE. Any illegal encoding returns to IDLE with the line high.
- Registers:
  - tick_cnt: 5 bits, so it can reach STOP_TICKS-1 = 31.
  - bit_idx: 3 bits.
  - shift_reg: DATA_BITS wide.
- IDLE:
  - o_tx_serial = 1, tick_cnt = 0, bit_idx = 0.
  - If i_tx_start = 1: load shift_reg <= i_tx_data and go to START.
- START:
  - o_tx_serial = 0.
  - On each i_tick, tick_cnt increments.
  - On the tick where tick_cnt == 15: tick_cnt <= 0, go to DATA.
- DATA:
  - o_tx_serial = shift_reg[0].
  - On the tick where tick_cnt == 15: tick_cnt <= 0 and shift_reg >> 1.
  - If bit_idx == DATA_BITS-1: bit_idx <= 0, go to STOP. Otherwise bit_idx + 1.
- STOP:
  - o_tx_serial = 1.
  - On the tick where tick_cnt == STOP_TICKS-1: tick_cnt <= 0, go to DONE.
- DONE:
  - o_tx_serial = 1, o_tx_done = 1 for exactly one cycle.
  - Next cycle unconditionally goes to IDLE. i_tx_start is ignored in DONE.
- i_tx_start in any state other than IDLE is ignored. No queuing; the upstream must wait for o_tx_busy = 0.
- i_tx_data is don't-care after acceptance. Changing it mid-frame must not alter the frame.
- Cycles without i_tick leave tick_cnt, bit_idx and shift_reg unchanged.

## Timing
- Reset (async assert, sync release): o_tx_serial = 1, o_tx_busy = 0, o_tx_done = 0, state = IDLE, all counters = 0.
- Reset asserted mid-frame:
  - The line returns high immediately and the frame is abandoned.
  - No done pulse.
- Acceptance:
  - Accept cycle N has i_tx_start = 1 in IDLE.
  - In cycle N+1: o_tx_serial = 0, o_tx_busy = 1.
- An i_tick in the accept cycle itself is not counted. The start bit lasts 16 ticks counted from cycle N+1.
- Each bit boundary: o_tx_serial changes on the clock edge that registers the 16th tick of the current bit. The output is registered, with no combinational path from inputs.
- Frame length from N+1 to the end of STOP: 16*(1+DATA_BITS) + STOP_TICKS ticks. Default = 160 ticks.
- o_tx_done is high in the cycle after the final stop tick. o_tx_busy is high in that same cycle and drops the next cycle.
- Back-to-back frames: the earliest next acceptance is the cycle after DONE, i.e. 2 cycles after the final stop tick. The line stays high in between.
- i_tick held high continuously: the block advances one tick per cycle. It must still produce a correct frame of 160 cycles (default parameters).

## Test plan
- After reset with i_tick running, no start request → o_tx_serial = 1, busy = 0, done = 0 for 500 cycles.
- Send 0x55 with i_tick every 16 clocks →
  - Line sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 256 clocks.
  - Stop bit high for 256 clocks.
  - done pulses once; busy drops 1 cycle after done.
- Send 0xA3, then assert i_tx_start with 0xFF on every cycle of the frame →
  - Only 0xA3 is sent (bits 1,1,0,0,0,1,0,1).
  - After DONE, the still-asserted start in IDLE begins a 0xFF frame.
- STOP_TICKS = 32, data 0x00 → 9 low bit periods, then high for 32 ticks before the done pulse.
- Assert i_reset_n = 0 during data bit 3 of a frame → o_tx_serial = 1 in the same cycle, busy = 0, no done pulse. A new 0x0F request after release transmits correctly.
- i_tick tied high, send 0x81 → 160-cycle frame, bits 1,0,0,0,0,0,0,1 LSB-first. Matches the receiver's loopback output 0x81 with the receiver's done bit asserted.
